// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline-stage buffers.
//   DATA_W_MEM_WB / CTRL_W_MEM_WB : default payload/control widths (MEM/WB)
//   occ_e                         : occupancy encodings reported by a stage
//   kill_amount()                 : number of held entries destroyed by a flush
// ---------------------------------------------------------------------------
package pipe_pkg;

  // ReadData 32 + ALU_Result 32 + rd 5
  localparam int DATA_W_MEM_WB = 69;
  // reg_wr, sel4, hlt
  localparam int CTRL_W_MEM_WB = 3;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Entries killed by a flush: the main entry unless it is leaving downstream
  // on the same edge, plus the skid entry.
  function automatic logic [1:0] kill_amount(input logic main_lost, input logic skid_lost);
    return {1'b0, main_lost} + {1'b0, skid_lost};
  endfunction

endpackage

// File: rtl/pipe_stage_skid_chk.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_chk
// Structural invariants of the skid stage.
//   clk, reset : stage clock and synchronous reset
//   m_valid    : main register valid
//   s_valid    : skid register valid
// ---------------------------------------------------------------------------
module pipe_stage_skid_chk (
  input logic clk,
  input logic reset,
  input logic m_valid,
  input logic s_valid
);

  // The skid register only ever holds the younger of two entries.
  skid_implies_main: assert property (@(posedge clk) disable iff (reset) (s_valid |-> m_valid))
    else $error("skid_implies_main violated: s_valid=1 with m_valid=0");

endmodule

// File: rtl/pipe_stage_skid_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter with a 0..2 increment per cycle that sticks at its maximum.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, clears the count
//   inc   : amount to add this cycle (0, 1 or 2)
//   count : current count, saturates at 2^W-1
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;
  logic [W:0]   sum_s;
  logic [W-1:0] count_n_s;

  // Next count: one extra bit catches the wrap so it can be clamped.
  always_comb begin
    sum_s     = {1'b0, count_r} + (W+1)'(inc);
    count_n_s = count_r;
    if (sum_s > {1'b0, {W{1'b1}}}) begin
      count_n_s = {W{1'b1}};
    end else begin
      count_n_s = sum_s[W-1:0];
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else begin
      count_r <= count_n_s;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
// Pipeline-stage register with valid/ready handshake and a 2-entry skid
// buffer, so in_ready depends only on local state (no combinational path from
// out_ready). Flush kills everything held plus any same-cycle input.
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   flush               : kill held entries and same-cycle input
//   in_valid/in_ready   : upstream handshake, in_data/in_ctrl payload
//   out_valid/out_ready : downstream handshake, out_data/out_ctrl payload
//   occupancy           : entries held, 0..2
//   kill_count          : saturating count of valid entries destroyed by flush
// ---------------------------------------------------------------------------
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W   = DATA_W_MEM_WB,
  parameter int CTRL_W   = CTRL_W_MEM_WB,
  parameter bit CLR_DATA = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  kill_count
);

  logic              m_valid_r, s_valid_r;
  logic [DATA_W-1:0] m_data_r,  s_data_r;
  logic [CTRL_W-1:0] m_ctrl_r,  s_ctrl_r;

  logic              m_valid_n_s, s_valid_n_s;
  logic [DATA_W-1:0] m_data_n_s,  s_data_n_s;
  logic [CTRL_W-1:0] m_ctrl_n_s,  s_ctrl_n_s;

  logic              in_ready_s, in_xfer_s, out_xfer_s;
  logic [1:0]        kill_inc_s;
  occ_e              occ_s;

  // Accept only while the skid slot is free; flush does not gate this.
  assign in_ready_s = ~reset & ~s_valid_r;
  assign in_xfer_s  = in_valid & in_ready_s;
  assign out_xfer_s = m_valid_r & out_ready;

  // Next-state of main and skid registers.
  always_comb begin
    m_valid_n_s = m_valid_r;
    m_data_n_s  = m_data_r;
    m_ctrl_n_s  = m_ctrl_r;
    s_valid_n_s = s_valid_r;
    s_data_n_s  = s_data_r;
    s_ctrl_n_s  = s_ctrl_r;
    if (flush) begin
      m_valid_n_s = 1'b0;
      m_ctrl_n_s  = '0;
      s_valid_n_s = 1'b0;
      s_ctrl_n_s  = '0;
      if (CLR_DATA) begin
        m_data_n_s = '0;
        s_data_n_s = '0;
      end else begin
        m_data_n_s = m_data_r;
        s_data_n_s = s_data_r;
      end
    end else if (!m_valid_r || out_xfer_s) begin
      // Main slot is free at this edge; the skid entry is older than any input.
      if (s_valid_r) begin
        m_valid_n_s = 1'b1;
        m_data_n_s  = s_data_r;
        m_ctrl_n_s  = s_ctrl_r;
        if (in_xfer_s) begin
          s_valid_n_s = 1'b1;
          s_data_n_s  = in_data;
          s_ctrl_n_s  = in_ctrl;
        end else begin
          s_valid_n_s = 1'b0;
          s_ctrl_n_s  = '0;
        end
      end else if (in_xfer_s) begin
        m_valid_n_s = 1'b1;
        m_data_n_s  = in_data;
        m_ctrl_n_s  = in_ctrl;
      end else begin
        // Bubble: ctrl is cleared so downstream write enables stay off.
        m_valid_n_s = 1'b0;
        m_ctrl_n_s  = '0;
      end
    end else begin
      // Main held by back-pressure; in_ready guarantees the skid is empty here.
      if (in_xfer_s) begin
        s_valid_n_s = 1'b1;
        s_data_n_s  = in_data;
        s_ctrl_n_s  = in_ctrl;
      end else begin
        s_valid_n_s = s_valid_r;
      end
    end
  end

  // Main and skid storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_r <= 1'b0;
      m_data_r  <= '0;
      m_ctrl_r  <= '0;
      s_valid_r <= 1'b0;
      s_data_r  <= '0;
      s_ctrl_r  <= '0;
    end else begin
      m_valid_r <= m_valid_n_s;
      m_data_r  <= m_data_n_s;
      m_ctrl_r  <= m_ctrl_n_s;
      s_valid_r <= s_valid_n_s;
      s_data_r  <= s_data_n_s;
      s_ctrl_r  <= s_ctrl_n_s;
    end
  end

  // Flush-kill increment; an entry consumed on the flush edge is not lost.
  always_comb begin
    kill_inc_s = 2'd0;
    if (flush) begin
      kill_inc_s = kill_amount(m_valid_r & ~out_xfer_s, s_valid_r);
    end else begin
      kill_inc_s = 2'd0;
    end
  end

  sat_counter #(.W(CNT_W)) u_kill_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (kill_inc_s),
    .count (kill_count)
  );

  // Occupancy encoding from the two valid bits.
  always_comb begin
    occ_s = OCC_EMPTY;
    case ({s_valid_r, m_valid_r})
      2'b00:   occ_s = OCC_EMPTY;
      2'b01:   occ_s = OCC_ONE;
      2'b11:   occ_s = OCC_FULL;
      default: occ_s = OCC_ONE;
    endcase
  end

  pipe_stage_skid_chk u_chk (
    .clk     (clk),
    .reset   (reset),
    .m_valid (m_valid_r),
    .s_valid (s_valid_r)
  );

  assign in_ready  = in_ready_s;
  assign out_valid = m_valid_r;
  assign out_data  = m_data_r;
  assign out_ctrl  = m_ctrl_r;
  assign occupancy = occ_s;

endmodule
